j4_fetch_ctrl: RTL and testbench

//  Program-memory owner and fetch sequencer for the j4 core. Holds the instruction
//  RAM, fills it from a valid/ready boot stream, then feeds instr = mem[pc] to the core.

---
 rtl/j4_fetch_ctrl.sv | 104 ++++++++++
 tb/tb_j4_fetch_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/j4_fetch_ctrl.sv
// Fetch sequencer and program RAM owner for the j4 core.
// It fills the RAM from a boot stream, then serves mem[pc] or parks the core with "jmp pc".
module j4_fetch_ctrl #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 13,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              load_last,
    input  logic [ADDR_W-1:0] pc,
    output logic [WIDTH-1:0]  instr,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic              resume_req,
    output logic              running,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_HALT,
        S_STEP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_load_addr;
    logic [CNT_W-1:0]  r_retired;
    logic [WIDTH-1:0]  r_mem [0:DEPTH-1];

    logic              w_load_fire;
    logic              w_load_final;
    logic              w_mem_we;
    logic              w_retire;

    always_comb begin
        w_load_fire  = (r_state == S_LOAD) && load_valid;
        w_load_final = w_load_fire && (load_last || (r_load_addr == LAST_ADDR));
        // Keep the RAM untouched while reset is held, even though load_ready reads 1.
        w_mem_we     = w_load_fire && !rst;
        w_retire     = (r_state == S_RUN) || (r_state == S_STEP);
    end

    // NOTE: every branch starts from a default so the next-state logic cannot infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD: if (w_load_final) w_state_nxt = S_RUN;
            S_RUN:  if (halt_req)     w_state_nxt = S_HALT;
            S_HALT: begin
                if (resume_req)    w_state_nxt = S_RUN;
                else if (step_req) w_state_nxt = S_STEP;
            end
            S_STEP: w_state_nxt = S_HALT;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_LOAD;
            r_load_addr <= '0;
            r_retired   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_fire)
                r_load_addr <= r_load_addr + ADDR_W'(1);
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    // NOTE: the RAM has no reset so it maps onto block memory; contents survive a reset.
    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[r_load_addr] <= load_data;
    end

    // HALT feeds "jmp pc", which is just the zero-extended pc.
    always_comb begin
        instr = '0;
        case (r_state)
            S_RUN, S_STEP: instr = r_mem[pc];
            S_HALT:        instr = WIDTH'(pc);
            default:       instr = '0;
        endcase
    end

    assign load_ready = (r_state == S_LOAD);
    assign running    = (r_state == S_RUN);
    assign halted     = (r_state == S_HALT);
    assign retired    = r_retired;

endmodule

// File: tb/tb_j4_fetch_ctrl.sv
// Self-checking bench for j4_fetch_ctrl.
// A behavioural model runs beside the DUT and is compared every cycle; directed literals pin the model.
module tb_j4_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = '0;
    logic        load_last = 1'b0;
    logic [12:0] pc = '0;
    logic [15:0] instr;
    logic        halt_req = 1'b0;
    logic        step_req = 1'b0;
    logic        resume_req = 1'b0;
    logic        running;
    logic        halted;
    logic [31:0] retired;

    int n_checks = 0;
    int n_errors = 0;

    j4_fetch_ctrl #(.WIDTH(16), .ADDR_W(13), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_last  (load_last),
        .pc         (pc),
        .instr      (instr),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .resume_req (resume_req),
        .running    (running),
        .halted     (halted),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: program image, load pointer, mode and retired count.
    typedef enum {M_LOAD, M_RUN, M_HALT, M_STEP} mode_t;
    mode_t       m_mode = M_LOAD;
    int          m_addr = 0;
    logic [31:0] m_ret  = 0;
    logic [15:0] m_mem [0:8191];
    bit          m_wr  [0:8191];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= M_LOAD;
            m_addr <= 0;
            m_ret  <= 0;
        end else begin
            case (m_mode)
                M_LOAD: if (load_valid) begin
                    m_mem[m_addr] <= load_data;
                    m_wr[m_addr]  <= 1'b1;
                    m_addr        <= m_addr + 1;
                    if (load_last || m_addr == 8191) m_mode <= M_RUN;
                end
                M_RUN: begin
                    m_ret <= m_ret + 1;
                    if (halt_req) m_mode <= M_HALT;
                end
                M_HALT: begin
                    if (resume_req)    m_mode <= M_RUN;
                    else if (step_req) m_mode <= M_STEP;
                end
                M_STEP: begin
                    m_ret  <= m_ret + 1;
                    m_mode <= M_HALT;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cmp_load_ready", {31'd0, load_ready}, {31'd0, m_mode == M_LOAD});
            check("cmp_running", {31'd0, running}, {31'd0, m_mode == M_RUN});
            check("cmp_halted", {31'd0, halted}, {31'd0, m_mode == M_HALT});
            check("cmp_retired", retired, m_ret);
            case (m_mode)
                M_LOAD: check("cmp_instr_load", {16'd0, instr}, 32'd0);
                M_HALT: check("cmp_instr_halt", {16'd0, instr}, {19'd0, pc});
                default: if (m_wr[pc]) check("cmp_instr_fetch", {16'd0, instr}, {16'd0, m_mem[pc]});
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_beat(input logic [15:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8192; i++) m_wr[i] = 1'b0;

        // Reset values
        repeat (2) step();
        check("rst_load_ready", {31'd0, load_ready}, 32'd1);
        check("rst_running", {31'd0, running}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_instr", {16'd0, instr}, 32'd0);
        rst = 1'b0;
        step();

        // Three-beat boot, last on the third
        load_beat(16'h8005, 1'b0);
        load_beat(16'h6000, 1'b0);
        load_beat(16'h0000, 1'b1);
        check("t1_ready_low", {31'd0, load_ready}, 32'd0);
        check("t1_running", {31'd0, running}, 32'd1);
        check("t1_instr_pc0", {16'd0, instr}, 32'h8005);
        check("t1_retired0", retired, 32'd0);
        step(); check("t1_retired1", retired, 32'd1);
        step(); check("t1_retired2", retired, 32'd2);
        step(); check("t1_retired3", retired, 32'd3);
        pc = 13'd1;
        #1 check("t1_instr_pc1", {16'd0, instr}, 32'h6000);

        // Halt at pc=2; pc and retired frozen
        pc = 13'd2;
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("t3_halted", {31'd0, halted}, 32'd1);
        check("t3_instr_jmp", {16'd0, instr}, 32'h0002);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_retired_frozen", retired, 32'd4);
            check("t3_instr_frozen", {16'd0, instr}, 32'h0002);
        end

        // Single step from pc=2, then core moves to pc=3
        step_req = 1'b1;
        step();
        step_req = 1'b0;
        check("t4_step_instr", {16'd0, instr}, 32'h0000);
        check("t4_step_not_halted", {31'd0, halted}, 32'd0);
        check("t4_step_not_running", {31'd0, running}, 32'd0);
        step();
        pc = 13'd3;
        #1;
        check("t4_back_halted", {31'd0, halted}, 32'd1);
        check("t4_retired", retired, 32'd5);
        check("t4_instr_jmp3", {16'd0, instr}, 32'h0003);

        // Step and resume together: resume wins
        pc = 13'd0;
        step_req = 1'b1; resume_req = 1'b1;
        step();
        step_req = 1'b0; resume_req = 1'b0;
        check("prio_resume_running", {31'd0, running}, 32'd1);
        check("prio_resume_instr", {16'd0, instr}, 32'h8005);
        // step_req ignored in RUN
        step_req = 1'b1;
        step();
        step_req = 1'b0;
        check("run_ignores_step", {31'd0, running}, 32'd1);
        check("run_retired6", retired, 32'd6);
        // halt_req ignored in HALT
        halt_req = 1'b1;
        step(); step();
        halt_req = 1'b0;
        check("halt_ignores_halt", {31'd0, halted}, 32'd1);
        check("halt_retired7", retired, 32'd7);
        // Requests ignored in STEP
        step_req = 1'b1;
        step();
        halt_req = 1'b1; resume_req = 1'b1;
        step();
        halt_req = 1'b0; resume_req = 1'b0; step_req = 1'b0;
        check("step_ignores_reqs", {31'd0, halted}, 32'd1);
        check("step_retired8", retired, 32'd8);

        // Asynchronous reset mid-RUN at pc=5
        resume_req = 1'b1;
        step();
        resume_req = 1'b0;
        pc = 13'd5;
        step();
        check("t6_pre_running", {31'd0, running}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_instr", {16'd0, instr}, 32'd0);
        check("t6_load_ready", {31'd0, load_ready}, 32'd1);
        check("t6_retired", retired, 32'd0);
        check("t6_running", {31'd0, running}, 32'd0);
        step();
        rst = 1'b0;
        pc = 13'd0;

        // Gapped reload overwrites from address 0
        load_beat(16'h1111, 1'b0);
        step(); check("t2_gap1_ready", {31'd0, load_ready}, 32'd1);
        load_beat(16'h2222, 1'b0);
        step(); check("t2_gap2_ready", {31'd0, load_ready}, 32'd1);
        load_beat(16'h3333, 1'b1);
        check("t2_ready_low", {31'd0, load_ready}, 32'd0);
        pc = 13'd0; #1 check("t2_mem0", {16'd0, instr}, 32'h1111);
        pc = 13'd1; #1 check("t2_mem1", {16'd0, instr}, 32'h2222);
        pc = 13'd2; #1 check("t2_mem2", {16'd0, instr}, 32'h3333);
        step();

        // Full-depth stream without load_last
        rst = 1'b1;
        step();
        rst = 1'b0;
        pc = 13'd0;
        for (int i = 0; i < 8192; i++) begin
            if (i == 8191) check("t5_ready_before_last", {31'd0, load_ready}, 32'd1);
            load_valid = 1'b1;
            load_data  = 16'(i) ^ 16'hA5A5;
            step();
        end
        load_data = 16'hFFFF;
        check("t5_ready_low", {31'd0, load_ready}, 32'd0);
        check("t5_running", {31'd0, running}, 32'd1);
        step();
        load_valid = 1'b0;
        pc = 13'd0;    #1 check("t5_no_wrap_mem0", {16'd0, instr}, 32'hA5A5);
        pc = 13'h1FFF; #1 check("t5_mem_top", {16'd0, instr}, 32'hBA5A);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
